// File: rtl/dw_inv_unit_seq.sv
// dw_inv_unit_seq: serialised inverse of the reduced Shadow round B (Dbox + 32-bit constant) on DW chunks
module dw_inv_unit_seq #(
   parameter int Nbits   = 128,
   parameter int BAmount = 4,
   parameter int DIVIDER = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [Nbits*BAmount-1:0] in_bundles_state,
   input  logic [127:0]             W128,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [Nbits*BAmount-1:0] out_bundles_state
);
   localparam int SNbits   = Nbits*BAmount;
   localparam int CHUNK_AM = 4/DIVIDER;
   localparam int CW       = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [SNbits-1:0] st_q, st_d, proc;
   logic [127:0]      w_q, w_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Undoes x0^=w, x1^=rotl(x0,1), x2^=rotl(x1',7), x3^=rotl(x2',13) word chain
   function automatic logic [127:0] dbox_inv_mls(input logic [127:0] y, input logic [31:0] w);
      logic [31:0] x0;
      x0 = y[31:0] ^ w;
      return {y[127:96] ^ rotl(y[95:64], 13), y[95:64] ^ rotl(y[63:32], 7),
              y[63:32] ^ rotl(x0, 1), x0};
   endfunction

   // Word k of bundle i <-> word i of DW chunk k; a square transpose, so it is its own inverse
   function automatic logic [SNbits-1:0] transpose(input logic [SNbits-1:0] s);
      logic [SNbits-1:0] r;
      r = '0;
      for (int i = 0; i < BAmount; i++)
         for (int k = 0; k < Nbits/32; k++)
            r[Nbits*k + 32*i +: 32] = s[Nbits*i + 32*k +: 32];
      return r;
   endfunction

   // Handshake FSM and the per-cycle chunk processing with rotation back to original order
   always_comb begin
      state_d   = state_q;
      st_d      = st_q;
      w_d       = w_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      proc      = '0;
      for (int c = 0; c < CHUNK_AM; c++)
         proc[Nbits*c +: Nbits] = dbox_inv_mls(st_q[Nbits*c +: Nbits], w_q[32*c +: 32]);
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_d    = transpose(in_bundles_state);
               w_d     = W128;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            st_d    = (st_q >> (Nbits*CHUNK_AM)) | (proc << (SNbits - Nbits*CHUNK_AM));
            w_d     = (w_q >> (32*CHUNK_AM)) | (w_q << (128 - 32*CHUNK_AM));
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(DIVIDER - 1)) ? DONE : BUSY;
         end
         DONE: begin
            out_valid = 1'b1;
            state_d   = out_ready ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_bundles_state = transpose(st_q);

   // State, data and constant registers with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         st_q    <= '0;
         w_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_dw_inv_unit_seq.sv
// tb_dw_inv_unit_seq: directed and random round-trip checks for DIVIDER 4, 2 and 1
module tb_dw_inv_unit_seq;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         iv   [3];
   logic         ir   [3];
   logic         ov   [3];
   logic         ordy [3];
   logic [511:0] ist  [3];
   logic [511:0] ost  [3];
   logic [127:0] wv   [3];
   int           total = 0;
   int           pass  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dw_inv_unit_seq #(.DIVIDER(4 >> g)) u_dut (
         .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]),
         .in_bundles_state(ist[g]), .W128(wv[g]), .out_valid(ov[g]),
         .out_ready(ordy[g]), .out_bundles_state(ost[g]));
   end

   function automatic logic [31:0] rl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Forward Dbox with constant on one chunk (the block's inverse must undo this)
   function automatic logic [127:0] dbox_mls(input logic [127:0] x, input logic [31:0] w);
      logic [31:0] t1, t2;
      t1 = x[63:32] ^ rl(x[31:0], 1);
      t2 = x[95:64] ^ rl(t1, 7);
      return {x[127:96] ^ rl(t2, 13), t2, t1, x[31:0] ^ w};
   endfunction

   // Forward round on a bundle-layout state: gather chunk k from word k of every bundle
   function automatic logic [511:0] dw_unit(input logic [511:0] s, input logic [127:0] w);
      logic [511:0] r;
      logic [127:0] ch;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) ch[32*i +: 32] = s[128*i + 32*k +: 32];
         ch = dbox_mls(ch, w[32*k +: 32]);
         for (int i = 0; i < 4; i++) r[128*i + 32*k +: 32] = ch[32*i +: 32];
      end
      return r;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s: got %h want %h", nm, got, exp);
   endtask

   task automatic start(input int d, input logic [511:0] s, input logic [127:0] w);
      int n = 0;
      @(negedge clk);
      while (!ir[d] && n < 50) begin @(negedge clk); n++; end
      ist[d] = s;
      wv[d]  = w;
      iv[d]  = 1'b1;
      @(negedge clk);
      iv[d]  = 1'b0;
   endtask

   task automatic wait_out(input int d, output int lat);
      lat = 0;
      while (!ov[d] && lat < 50) begin @(negedge clk); lat++; end
   endtask

   typedef struct {
      logic [511:0] st;
      logic [127:0] w;
      logic [511:0] exp;
   } vec_t;

   vec_t         vecs [6];
   logic [511:0] x, hold;
   logic [511:0] q [$];
   int           lat, sent, got;
   logic         pend;

   initial begin
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b1; ist[d] = '0; wv[d] = '0;
      end
      x = {8{64'h0123456789abcdef}};
      vecs[0] = '{dw_unit(x, 128'h00000001_00000002_00000004_00000008), 128'h00000001_00000002_00000004_00000008, x};
      vecs[1] = '{512'h0, 128'h0, 512'h0};
      vecs[2] = '{512'h0, 128'h1, {352'h0, 32'h2, 96'h0, 32'h1}};
      x = '1;
      vecs[3] = '{dw_unit(x, 128'h0), 128'h0, x};
      x = 512'h1 << 300;
      vecs[4] = '{dw_unit(x, 128'hdeadbeef_00000000_80000000_12345678), 128'hdeadbeef_00000000_80000000_12345678, x};
      x = {16{32'ha5a5_5a5a}};
      vecs[5] = '{dw_unit(x, '1), '1, x};

      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_out_valid_d%0d", d), 512'(ov[d]), 512'h0);
         chk($sformatf("reset_in_ready_d%0d", d), 512'(ir[d]), 512'h1);
         chk($sformatf("reset_out_d%0d", d), ost[d], 512'h0);
      end
      rst = 1'b0;

      for (int v = 0; v < 6; v++)
         for (int d = 0; d < 3; d++) begin
            start(d, vecs[v].st, vecs[v].w);
            wait_out(d, lat);
            chk($sformatf("vec%0d_data_d%0d", v, d), ost[d], vecs[v].exp);
            chk($sformatf("vec%0d_latency_d%0d", v, d), 512'(lat), 512'(4 >> d));
         end

      ordy[0] = 1'b0;
      start(0, vecs[0].st, vecs[0].w);
      wait_out(0, lat);
      hold = ost[0];
      chk("bp_data", hold, vecs[0].exp);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("bp_valid_c%0d", c), 512'(ov[0]), 512'h1);
         chk($sformatf("bp_hold_c%0d", c), ost[0], hold);
         chk($sformatf("bp_in_ready_c%0d", c), 512'(ir[0]), 512'h0);
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 512'(ov[0]), 512'h0);
      chk("bp_release_in_ready", 512'(ir[0]), 512'h1);

      start(0, vecs[4].st, vecs[4].w);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", 512'(ov[0]), 512'h0);
      chk("abort_in_ready", 512'(ir[0]), 512'h1);
      chk("abort_out", ost[0], 512'h0);
      start(0, vecs[5].st, vecs[5].w);
      wait_out(0, lat);
      chk("after_abort_data", ost[0], vecs[5].exp);

      sent = 0; got = 0; pend = 1'b0;
      for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
         @(negedge clk);
         if (!pend && sent < 200) begin
            x = rnd512();
            wv[0] = {$urandom, $urandom, $urandom, $urandom};
            ist[0] = dw_unit(x, wv[0]);
            pend = 1'b1;
         end
         iv[0]   = pend && ($urandom_range(0, 1) == 1);
         ordy[0] = ($urandom_range(0, 3) != 0);
         if (ov[0] && ordy[0]) begin
            if (q.size() == 0) chk($sformatf("rand_unexpected_%0d", got), ost[0], 512'hx);
            else chk($sformatf("rand_data_%0d", got), ost[0], q.pop_front());
            got++;
         end
         if (iv[0] && ir[0]) begin
            q.push_back(x);
            sent++;
            pend = 1'b0;
         end
      end
      iv[0] = 1'b0;
      chk("rand_received", 512'(got), 512'd200);
      chk("rand_leftover", 512'(q.size()), 512'h0);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
